// File: rtl/fx68k_div_seq_pkg.sv
// +--------------------------------------------------------------------------+
// | fx68kPkg: CCR bit indices and divider sequencer state encoding.          |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package fx68kPkg;

  localparam int unsigned CF = 0;
  localparam int unsigned VF = 1;
  localparam int unsigned ZF = 2;
  localparam int unsigned NF = 3;
  localparam int unsigned XF = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    STEP = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } divSeqState;

endpackage

`default_nettype wire

// File: rtl/fx68k_div_seq_step.sv
// +--------------------------------------------------------------------------+
// | fx68kDivStep: one restoring shift/compare/subtract divide step.          |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module fx68kDivStep (
  input  logic [16:0] rem_i,
  input  logic [15:0] quo_i,
  input  logic [15:0] divisor_i,
  output logic [16:0] rem_o,
  output logic [15:0] quo_o,
  output logic        qBit_o
);

  logic [16:0] w_shRem;
  logic [16:0] w_diff;

  assign w_shRem = {rem_i[15:0], quo_i[15]};
  assign w_diff  = w_shRem - {1'b0, divisor_i};
  // rem_i[16] set means the shifted value exceeds any 16-bit divisor.
  assign qBit_o  = rem_i[16] | (w_shRem >= {1'b0, divisor_i});
  assign rem_o   = qBit_o ? w_diff : w_shRem;
  // Shifted quotient with an empty LSB; the caller merges qBit_o.
  assign quo_o   = {quo_i[14:0], 1'b0};

endmodule

`default_nettype wire

// File: rtl/fx68k_div_seq.sv
// +--------------------------------------------------------------------------+
// | fx68k_div_seq: iterative 32/16 DIVU/DIVS sequencer gated by enT3.         |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module fx68k_div_seq
  import fx68kPkg::*;
#(
  parameter int unsigned STEPS = 16
) (
  input  logic        clk,
  input  logic        pwrUp_n,
  input  logic        enT3,
  input  logic        start,
  input  logic        isSigned,
  input  logic [31:0] dividend,
  input  logic [15:0] divisor,
  input  logic        xIn,
  output logic        busy,
  output logic        done,
  output logic        divZero,
  output logic [15:0] quotient,
  output logic [15:0] remainder,
  output logic [4:0]  ccrOut,
  output logic        ccrWe
);

  divSeqState  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [16:0] rem_q, rem_d;
  logic [15:0] quo_q, quo_d;
  logic [15:0] divMag_q, divMag_d;
  logic [31:0] dividend_q, dividend_d;
  logic [15:0] divisor_q, divisor_d;
  logic        isSigned_q, isSigned_d;
  logic        dz_q, dz_d;
  logic        ovf_q, ovf_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        divZero_q, divZero_d;
  logic [15:0] quotient_q, quotient_d;
  logic [15:0] remainder_q, remainder_d;
  logic [4:0]  ccr_q, ccr_d;
  logic        ccrWe_q, ccrWe_d;

  logic [31:0] w_magDvd;
  logic [15:0] w_magDvs;
  logic        w_dz;
  logic        w_ovf;
  logic        w_negQ;
  logic        w_negR;
  logic [15:0] w_qRes;
  logic [15:0] w_rRes;
  logic        w_sOvf;
  logic [16:0] w_stepRem;
  logic [15:0] w_stepQuo;
  logic        w_stepBit;

  fx68kDivStep u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (divMag_q),
    .rem_o     (w_stepRem),
    .quo_o     (w_stepQuo),
    .qBit_o    (w_stepBit)
  );

  assign w_magDvd = (isSigned_q && dividend_q[31]) ? (32'd0 - dividend_q) : dividend_q;
  assign w_magDvs = (isSigned_q && divisor_q[15])  ? (16'd0 - divisor_q)  : divisor_q;
  assign w_dz     = (divisor_q == 16'd0);
  assign w_ovf    = !w_dz && (w_magDvd[31:16] >= w_magDvs);

  assign w_negQ   = isSigned_q && (dividend_q[31] ^ divisor_q[15]);
  assign w_negR   = isSigned_q && dividend_q[31];
  assign w_qRes   = w_negQ ? (16'd0 - quo_q) : quo_q;
  assign w_rRes   = w_negR ? (16'd0 - rem_q[15:0]) : rem_q[15:0];
  assign w_sOvf   = isSigned_q && (w_negQ ? (quo_q > 16'h8000) : (quo_q > 16'h7FFF));

  always_ff @(posedge clk or negedge pwrUp_n) begin
    if (!pwrUp_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      rem_q       <= 17'd0;
      quo_q       <= 16'd0;
      divMag_q    <= 16'd0;
      dividend_q  <= 32'd0;
      divisor_q   <= 16'd0;
      isSigned_q  <= 1'b0;
      dz_q        <= 1'b0;
      ovf_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      divZero_q   <= 1'b0;
      quotient_q  <= 16'd0;
      remainder_q <= 16'd0;
      ccr_q       <= 5'd0;
      ccrWe_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      divMag_q    <= divMag_d;
      dividend_q  <= dividend_d;
      divisor_q   <= divisor_d;
      isSigned_q  <= isSigned_d;
      dz_q        <= dz_d;
      ovf_q       <= ovf_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      divZero_q   <= divZero_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      ccr_q       <= ccr_d;
      ccrWe_q     <= ccrWe_d;
    end
  end

  // Early exits still pass through FIX so results land one edge after PREP.
  always_comb begin
    state_d = state_q;
    if (enT3) begin
      case (state_q)
        IDLE, DONE: if (start) state_d = PREP;
        PREP:       state_d = (w_dz || w_ovf) ? FIX : STEP;
        STEP:       if (cnt_q == 4'd0) state_d = FIX;
        FIX:        state_d = DONE;
        default:    state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    divMag_d    = divMag_q;
    dividend_d  = dividend_q;
    divisor_d   = divisor_q;
    isSigned_d  = isSigned_q;
    dz_d        = dz_q;
    ovf_d       = ovf_q;
    divZero_d   = divZero_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    ccr_d       = ccr_q;
    if (enT3) begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            dividend_d = dividend;
            divisor_d  = divisor;
            isSigned_d = isSigned;
            divZero_d  = 1'b0;
          end
        end
        PREP: begin
          dz_d     = w_dz;
          ovf_d    = w_ovf;
          divMag_d = w_magDvs;
          rem_d    = {1'b0, w_magDvd[31:16]};
          quo_d    = w_magDvd[15:0];
          cnt_d    = 4'(STEPS - 1);
        end
        STEP: begin
          rem_d = w_stepRem;
          quo_d = w_stepQuo | {15'd0, w_stepBit};
          cnt_d = cnt_q - 4'd1;
        end
        FIX: begin
          ccr_d     = 5'd0;
          ccr_d[XF] = xIn;
          if (dz_q) begin
            divZero_d   = 1'b1;
            quotient_d  = dividend_q[15:0];
            remainder_d = dividend_q[31:16];
          end else if (ovf_q || w_sOvf) begin
            ccr_d[VF]   = 1'b1;
            quotient_d  = dividend_q[15:0];
            remainder_d = dividend_q[31:16];
          end else begin
            ccr_d[NF]   = w_qRes[15];
            ccr_d[ZF]   = (w_qRes == 16'd0);
            quotient_d  = w_qRes;
            remainder_d = w_rRes;
          end
        end
        default: ;
      endcase
    end
    busy_d  = (state_d == PREP) || (state_d == STEP) || (state_d == FIX);
    done_d  = (state_d == DONE);
    ccrWe_d = done_d && !divZero_d;
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign divZero   = divZero_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign ccrOut    = ccr_q;
  assign ccrWe     = ccrWe_q;

endmodule

`default_nettype wire

// File: tb/tb_fx68k_div_seq.sv
// +--------------------------------------------------------------------------+
// | tb_fx68k_div_seq: directed self-checking bench for fx68k_div_seq.        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_fx68k_div_seq;

  logic        clk;
  logic        pwrUp_n;
  logic        enT3;
  logic        start;
  logic        isSigned;
  logic [31:0] dividend;
  logic [15:0] divisor;
  logic        xIn;
  logic        busy;
  logic        done;
  logic        divZero;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic [4:0]  ccrOut;
  logic        ccrWe;

  int checks = 0;
  int errors = 0;
  int t3Div  = 1;

  fx68k_div_seq #(.STEPS(16)) dut (
    .clk       (clk),
    .pwrUp_n   (pwrUp_n),
    .enT3      (enT3),
    .start     (start),
    .isSigned  (isSigned),
    .dividend  (dividend),
    .divisor   (divisor),
    .xIn       (xIn),
    .busy      (busy),
    .done      (done),
    .divZero   (divZero),
    .quotient  (quotient),
    .remainder (remainder),
    .ccrOut    (ccrOut),
    .ccrWe     (ccrWe)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // enT3 is updated just after each rising edge and holds for the next one.
  initial begin
    int ph;
    ph   = 0;
    enT3 = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ph++;
      enT3 = ((ph % t3Div) == 0);
    end
  end

  task automatic launch(input logic [31:0] dvd, input logic [15:0] dvs, input logic sgn);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!enT3 && guard < 16) begin
      @(negedge clk);
      guard++;
    end
    dividend = dvd;
    divisor  = dvs;
    isSigned = sgn;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts enT3 edges after the accepting edge until done is seen.
  task automatic wait_done(output int edges, input bit interfere);
    edges = 0;
    checks++;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (done) return;
      if (interfere && edges == 5 && enT3) begin
        start    = 1'b1;
        dividend = 32'hFFFF_FFFF;
        divisor  = 16'h0001;
      end else begin
        start = 1'b0;
      end
      if (enT3) edges++;
    end
    errors++;
    $display("FAIL wait_done: done not seen, got %0d edges, required done within 400 cycles", edges);
    edges = -1;
  endtask

  task automatic test_reset;
    pwrUp_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, divZero, ccrWe, quotient, remainder, ccrOut} !== 41'd0) begin
      errors++;
      $display("FAIL reset_state: got b%b d%b z%b w%b q%h r%h c%b, required all zero",
               busy, done, divZero, ccrWe, quotient, remainder, ccrOut);
    end
    pwrUp_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_unsigned;
    int e;
    xIn = 1'b1;
    launch(32'h0001_0000, 16'h0002, 1'b0);
    wait_done(e, 1'b0);
    checks++; if (e !== 18) begin errors++; $display("FAIL divu_latency: got %0d required 18", e); end
    checks++; if (quotient !== 16'h8000) begin errors++; $display("FAIL divu_quot: got %h required 8000", quotient); end
    checks++; if (remainder !== 16'h0000) begin errors++; $display("FAIL divu_rem: got %h required 0000", remainder); end
    checks++; if ({ccrOut, ccrWe, divZero, busy} !== 8'b11000_1_0_0) begin
      errors++; $display("FAIL divu_flags: got ccr %b we %b dz %b busy %b, required 11000 1 0 0", ccrOut, ccrWe, divZero, busy);
    end
  endtask

  task automatic test_signed;
    int e;
    xIn = 1'b0;
    launch(32'hFFFF_FFF9, 16'h0002, 1'b1);
    wait_done(e, 1'b0);
    checks++; if (e !== 18) begin errors++; $display("FAIL divs_latency: got %0d required 18", e); end
    checks++; if (quotient !== 16'hFFFD) begin errors++; $display("FAIL divs_quot: got %h required fffd", quotient); end
    checks++; if (remainder !== 16'hFFFF) begin errors++; $display("FAIL divs_rem: got %h required ffff", remainder); end
    checks++; if (ccrOut !== 5'b01000) begin errors++; $display("FAIL divs_ccr: got %b required 01000", ccrOut); end
  endtask

  task automatic test_div_zero;
    int e;
    xIn = 1'b1;
    launch(32'h1234_5678, 16'h0000, 1'b0);
    wait_done(e, 1'b0);
    checks++; if (e !== 2) begin errors++; $display("FAIL dz_latency: got %0d required 2", e); end
    checks++; if ({divZero, ccrWe} !== 2'b10) begin errors++; $display("FAIL dz_flags: got dz %b we %b required dz 1 we 0", divZero, ccrWe); end
    checks++; if ({remainder, quotient} !== 32'h1234_5678) begin
      errors++; $display("FAIL dz_result: got r %h q %h required r 1234 q 5678", remainder, quotient);
    end
    checks++; if (ccrOut !== 5'b10000) begin errors++; $display("FAIL dz_ccr: got %b required 10000", ccrOut); end
  endtask

  task automatic test_overflow;
    int e;
    xIn = 1'b0;
    launch(32'h0002_0000, 16'h0001, 1'b0);
    wait_done(e, 1'b0);
    checks++; if (e !== 2) begin errors++; $display("FAIL uovf_latency: got %0d required 2", e); end
    checks++; if ({remainder, quotient} !== 32'h0002_0000) begin
      errors++; $display("FAIL uovf_result: got r %h q %h required r 0002 q 0000", remainder, quotient);
    end
    checks++; if ({ccrOut, ccrWe} !== 6'b00010_1) begin errors++; $display("FAIL uovf_ccr: got %b we %b required 00010 we 1", ccrOut, ccrWe); end
    launch(32'h0000_8000, 16'h0001, 1'b1);
    wait_done(e, 1'b0);
    checks++; if (e !== 18) begin errors++; $display("FAIL sovf_latency: got %0d required 18", e); end
    checks++; if ({remainder, quotient} !== 32'h0000_8000) begin
      errors++; $display("FAIL sovf_result: got r %h q %h required r 0000 q 8000", remainder, quotient);
    end
    checks++; if (ccrOut !== 5'b00010) begin errors++; $display("FAIL sovf_ccr: got %b required 00010", ccrOut); end
  endtask

  task automatic test_back_to_back;
    int e;
    xIn = 1'b1;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_pre_done: got %b required 1", done); end
    launch(32'h0000_0003, 16'hFFFB, 1'b1);
    checks++; if ({done, busy} !== 2'b01) begin errors++; $display("FAIL b2b_handoff: got done %b busy %b required done 0 busy 1", done, busy); end
    wait_done(e, 1'b0);
    checks++; if (e !== 18) begin errors++; $display("FAIL b2b_latency: got %0d required 18", e); end
    checks++; if ({quotient, remainder} !== 32'h0000_0003) begin
      errors++; $display("FAIL b2b_result: got q %h r %h required q 0000 r 0003", quotient, remainder);
    end
    checks++; if (ccrOut !== 5'b10100) begin errors++; $display("FAIL b2b_ccr: got %b required 10100", ccrOut); end
  endtask

  task automatic test_slow_enable;
    int e;
    logic [15:0] held;
    bit stable;
    t3Div = 4;
    xIn   = 1'b1;
    launch(32'h0001_0000, 16'h0002, 1'b0);
    wait_done(e, 1'b0);
    checks++; if (e !== 18) begin errors++; $display("FAIL slow_divu_latency: got %0d required 18", e); end
    checks++; if ({quotient, remainder, ccrOut} !== {16'h8000, 16'h0000, 5'b11000}) begin
      errors++; $display("FAIL slow_divu_result: got q %h r %h c %b required q 8000 r 0000 c 11000", quotient, remainder, ccrOut);
    end
    xIn = 1'b0;
    launch(32'hFFFF_FFF9, 16'h0002, 1'b1);
    wait_done(e, 1'b1);
    checks++; if (e !== 18) begin errors++; $display("FAIL slow_busy_start_latency: got %0d required 18", e); end
    checks++; if ({quotient, remainder, ccrOut} !== {16'hFFFD, 16'hFFFF, 5'b01000}) begin
      errors++; $display("FAIL slow_busy_start_result: got q %h r %h c %b required q fffd r ffff c 01000", quotient, remainder, ccrOut);
    end
    held   = quotient;
    stable = 1'b1;
    start  = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (!done || quotient !== held) stable = 1'b0;
    end
    checks++; if (stable !== 1'b1) begin errors++; $display("FAIL done_hold: got q %h done %b required q %h done 1", quotient, done, held); end
    t3Div = 1;
  endtask

  task automatic test_async_reset;
    int e;
    xIn = 1'b0;
    launch(32'h1234_5678, 16'h7FFF, 1'b0);
    e = 0;
    for (int c = 0; c < 100 && e < 8; c++) begin
      @(negedge clk);
      if (enT3) e++;
    end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_run_busy: got %b required 1", busy); end
    pwrUp_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, divZero, ccrWe, quotient, remainder, ccrOut} !== 41'd0) begin
      errors++;
      $display("FAIL async_reset: got b%b d%b z%b w%b q%h r%h c%b, required all zero",
               busy, done, divZero, ccrWe, quotient, remainder, ccrOut);
    end
    repeat (2) @(negedge clk);
    pwrUp_n = 1'b1;
    launch(32'h0000_0064, 16'h000A, 1'b0);
    wait_done(e, 1'b0);
    checks++; if (e !== 18) begin errors++; $display("FAIL post_reset_latency: got %0d required 18", e); end
    checks++; if ({quotient, remainder, ccrOut, ccrWe} !== {16'h000A, 16'h0000, 5'b00000, 1'b1}) begin
      errors++; $display("FAIL post_reset_result: got q %h r %h c %b we %b required q 000a r 0000 c 00000 we 1",
                         quotient, remainder, ccrOut, ccrWe);
    end
  endtask

  initial begin
    pwrUp_n  = 1'b0;
    start    = 1'b0;
    isSigned = 1'b0;
    dividend = 32'd0;
    divisor  = 16'd0;
    xIn      = 1'b0;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_back_to_back();
    test_slow_enable();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fx68k_div_seq.md
# fx68k_div_seq

Iterative 32÷16 divider that performs the inverse of the ALU's multiply path (DIVU/DIVS). It accepts a 32-bit dividend and 16-bit divisor, runs a 16-step restoring shift-subtract loop gated by the T3 phase enable, and returns quotient, remainder and an ALU-format condition-code vector with a write strobe. The microsequencer drives it, and the core's register and CCR write-back consume its results.

## Interface
Parameters:
- STEPS, 16, number of quotient bits produced; fixed at 16 for 68000 semantics

Ports:
- clk  in  1  core clock
- pwrUp_n  in  1  asynchronous active-low reset
- enT3  in  1  phase enable; all state advances only on clk edges with enT3=1
- start  in  1  launch request, sampled when enT3=1 in IDLE or DONE
- isSigned  in  1  1 = DIVS, 0 = DIVU; latched at start
- dividend  in  32  latched at start
- divisor  in  16  latched at start
- xIn  in  1  current X flag, passed through to ccrOut[4]
- busy  out  1  high in PREP, STEP and FIX
- done  out  1  high in DONE
- divZero  out  1  divisor was 0; valid while done
- quotient  out  16  result quotient; valid while done
- remainder  out  16  result remainder; valid while done
- ccrOut  out  5  {X,N,Z,V,C}, with C at bit 0, V at 1, Z at 2, N at 3, X at 4
- ccrWe  out  1  high while done and divZero=0

## Operation
- States: IDLE → PREP → STEP(×16) → FIX → DONE. From DONE, start relaunches and otherwise the block holds.
- start is ignored while busy.
- PREP:
  - divisor==0: set divZero=1, ccrOut={xIn,4'b0}, go to DONE. ccrWe stays 0.
  - Otherwise form magnitudes: |dividend| (32b) and |divisor| (16b). In unsigned mode use the raw values.
  - If the magnitude high word is ≥ the magnitude divisor, this is overflow: go to DONE with V=1.
  - Otherwise load the partial remainder and go to STEP with the count set to 15.
- STEP:
  - Shift {rem[16:0], quo[15:0]} left by 1.
  - If rem ≥ divisor magnitude (17-bit compare), subtract it and set quotient bit 1.
  - The count decrements; at count 0, go to FIX.
- FIX (signed only; unsigned passes values through):
  - Negate the quotient if the operand signs differ.
  - Negate the remainder if the dividend is negative.
  - Signed overflow: positive quotient > 0x7FFF, or negative quotient magnitude > 0x8000. Signed overflow sets V=1.
- Result rules:
  - Normal: N=quotient[15], Z=(quotient==0), V=0, C=0.
  - Overflow: V=1, N=0, Z=0, C=0. The destination is left unchanged: quotient=dividend[15:0], remainder=dividend[31:16].
  - Division by zero: quotient=dividend[15:0], remainder=dividend[31:16].
- Reset (async, any state): state=IDLE. busy, done, divZero, ccrWe=0; quotient, remainder, ccrOut=0.
- enT3=0 freezes every register. Outputs are stable in this case.

## Timing
- Let k be the enT3 edge at which start is accepted.
- Normal completion: done rises after enT3 edge k+18. The sequence is PREP at k+1, steps at k+2..k+17, FIX at k+18.
- Early exit (divide by zero or unsigned/magnitude overflow): done rises after edge k+2.
- Relaunch from DONE: done drops after the accepting edge, and busy rises in the same cycle.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Outputs hold their values throughout DONE until the next accepted start or reset.

## Structure
- Shared package fx68kPkg holds:
  - CCR bit indices CF=0, VF=1, ZF=2, NF=3, XF=4, common with the ALU.
  - The divSeqState enum (IDLE, PREP, STEP, FIX, DONE).
- One sub-module, fx68kDivStep, is the combinational single-step shift/compare/subtract: it takes rem, quo and divisor, and produces the next rem, quo and quotient bit. It is reusable by a future radix-4 variant.
- The step counter is 4 bits.

## Test plan
- Unsigned 0x0001_0000 / 0x0002: expect quotient 0x8000, remainder 0, ccrOut=X,1,0,0,0, done after 18 enT3 edges.
- Signed 0xFFFF_FFF9 (-7) / 0x0002: expect quotient 0xFFFD, remainder 0xFFFF, N=1, Z=0, V=0.
- Divisor 0: expect divZero=1, ccrWe=0, quotient and remainder equal to the dividend halves, done after 2 edges.
- Unsigned 0x0002_0000 / 0x0001 (early overflow) and signed 0x0000_8000 / 0x0001 (FIX overflow): expect V=1, N=Z=C=0, quotient=dividend[15:0], remainder=dividend[31:16].
- Run with enT3 asserted every 4th clk: expect identical results, the latency counted in enT3 edges, and start ignored while busy.
- Assert pwrUp_n low at step 7, then restart with 0x0000_0064 / 0x000A: expect all outputs 0 immediately on reset, and the next run returns quotient 0x000A, remainder 0.
